// File: rtl/fifo_read_controller_pkg.sv
// Shared definitions for the FIFO read controller: FSM state encoding,
// legal configuration range and the FIFO-facing bundle widths.
package fifo_read_controller_pkg;

  // Controller states; the numeric values are fixed so they read the same in waveforms
  typedef enum logic [1:0] {
    S_NO_CONFIG = 2'd0,
    S_IDLE      = 2'd1,
    S_POP       = 2'd2,
    S_RECOVER   = 2'd3
  } rdState_e;

  // Width of the sub-buffer count sent to the FIFO
  localparam int CFG_WIDTH = 3;

  // Legal range for the active sub-buffer count
  localparam logic [CFG_WIDTH-1:0] CFG_MIN = 3'd1;
  localparam logic [CFG_WIDTH-1:0] CFG_MAX = 3'd4;

  // Default widths of the FIFO-facing bundle
  localparam int DEFAULT_DATA_WIDTH      = 8;
  localparam int DEFAULT_SUBBUFFER_DEPTH = 4;
  localparam int DEFAULT_CNT_WIDTH       = 5;

  // True when a sub-buffer count can be handed to the FIFO
  function automatic logic cfgLegal(input logic [CFG_WIDTH-1:0] units);
    return (units >= CFG_MIN) && (units <= CFG_MAX);
  endfunction

endpackage

// File: rtl/fifo_read_controller.sv
// Flow-control wrapper around the configurable sub-buffer FIFO. It accepts
// upstream samples, paces pops around the FIFO's post-pop recovery slot,
// keeps its own occupancy count (the FIFO has no empty flag) and presents
// popped words through a registered valid/ready port.
module fifo_read_controller
  import fifo_read_controller_pkg::*;
#(
  parameter int DATA_WIDTH      = DEFAULT_DATA_WIDTH,
  parameter int SUBBUFFER_DEPTH = DEFAULT_SUBBUFFER_DEPTH,
  parameter int CNT_WIDTH       = DEFAULT_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  cfg_save,
  input  logic [CFG_WIDTH-1:0]  cfg_units,
  input  logic                  in_valid,
  input  logic [DATA_WIDTH-1:0] in_data,
  output logic                  in_ready,
  output logic                  fifo_push,
  output logic                  fifo_pop,
  output logic [DATA_WIDTH-1:0] fifo_data_in,
  output logic                  fifo_save_config,
  output logic [CFG_WIDTH-1:0]  fifo_configuration,
  output logic                  fifo_reset_data,
  output logic                  fifo_reset_config,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  output logic                  out_valid,
  output logic [DATA_WIDTH-1:0] out_data,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  occupancy,
  output logic                  configured
);

  localparam logic [CNT_WIDTH-1:0] DEPTH_CNT = CNT_WIDTH'(SUBBUFFER_DEPTH);
  localparam logic [CNT_WIDTH-1:0] ONE_CNT   = CNT_WIDTH'(1);

  rdState_e              state_q;
  logic [CNT_WIDTH-1:0]  occupancy_q;
  logic [CNT_WIDTH-1:0]  capacity_q;
  logic                  configured_q;
  logic                  outValid_q;
  logic [DATA_WIDTH-1:0] outData_q;

  logic clear;
  logic inReady;
  logic pushFire;
  logic popFire;
  logic loadOut;
  logic startPop;

  // Reset and flush both wipe the FIFO contents and its configuration
  assign clear = reset || flush;

  // Samples are only taken while idle and below capacity; never during a clear
  always_comb begin
    inReady = 1'b0;
    if (!clear && (state_q == S_IDLE)) begin
      inReady = (occupancy_q < capacity_q);
    end
  end

  assign pushFire = in_valid && inReady;
  assign popFire  = !clear && (state_q == S_POP);
  assign loadOut  = (state_q == S_RECOVER);

  // A word pushed this cycle counts as available so an empty FIFO pops on the next cycle
  assign startPop = ((occupancy_q != '0) || pushFire) && (!outValid_q || out_ready);

  // Controller FSM: configuration latch, then idle/pop/recover cycling
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q      <= S_NO_CONFIG;
      capacity_q   <= '0;
      configured_q <= 1'b0;
    end else begin
      case (state_q)
        S_NO_CONFIG: begin
          if (cfg_save && cfgLegal(cfg_units)) begin
            capacity_q   <= CNT_WIDTH'(cfg_units) * DEPTH_CNT;
            configured_q <= 1'b1;
            state_q      <= S_IDLE;
          end
        end
        S_IDLE: begin
          if (startPop) begin
            state_q <= S_POP;
          end
        end
        S_POP:     state_q <= S_RECOVER;
        S_RECOVER: state_q <= S_IDLE;
        default:   state_q <= S_NO_CONFIG;
      endcase
    end
  end

  // Occupancy tracking; push and pop live in different states so they never coincide
  always_ff @(posedge clk) begin
    if (clear) begin
      occupancy_q <= '0;
    end else if (pushFire) begin
      occupancy_q <= occupancy_q + ONE_CNT;
    end else if (popFire) begin
      occupancy_q <= occupancy_q - ONE_CNT;
    end
  end

  // Output register: a freshly recovered word wins over a same-cycle consume
  always_ff @(posedge clk) begin
    if (clear) begin
      outValid_q <= 1'b0;
      outData_q  <= '0;
    end else if (loadOut) begin
      outValid_q <= 1'b1;
      outData_q  <= fifo_data_out;
    end else if (outValid_q && out_ready) begin
      outValid_q <= 1'b0;
    end
  end

  assign in_ready           = inReady;
  assign fifo_push          = pushFire;
  assign fifo_pop           = popFire;
  assign fifo_data_in       = in_data;
  assign fifo_save_config   = (state_q == S_NO_CONFIG) && cfg_save;
  assign fifo_configuration = cfg_units;
  assign fifo_reset_data    = clear;
  assign fifo_reset_config  = clear;
  assign out_valid          = outValid_q;
  assign out_data           = outData_q;
  assign occupancy          = occupancy_q;
  assign configured         = configured_q;

endmodule
